sum_bcd_pager: RTL and testbench
================================

# sum_bcd_pager

Downstream display-preparation stage for the N-Queens accelerator result. Captures the 64-bit solution count when the accelerator raises `done`, converts it to 20 BCD digits with an iterative double-dabble engine, then pages through the result eight digits at a time with leading-zero blanking. Its outputs feed the eight-digit seven-segment display driver directly, replacing the raw 32-bit half-word selection of the hex sum.

## Interface
- `PAGE_CYCLES`, default 268435456, number of clock cycles each page is shown (minimum 2; benches use small values).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `sum`  in  64  unsigned solution count from the accelerator; sampled only at capture.
- `done`  in  1  accelerator completion level; a rising edge triggers capture.
- `digits`  out  32  eight BCD nibbles of the current page; nibble i (`[4i+3:4i]`) is global digit 8·page+i, digit 0 = least significant.
- `blank`  out  8  per-digit blank mask; bit i = 1 means the display driver shows nothing for nibble i.
- `page`  out  2  current page index, 0..2.
- `busy`  out  1  conversion in progress.
- `valid`  out  1  `digits`/`blank` reflect a completed conversion.

## Operation
- State machine: IDLE, CONVERT, SHOW. `done_q` is `done` delayed one cycle; capture event = `done & ~done_q`.
- IDLE: on a capture event, load `sum` into a 64-bit shift register, clear the 80-bit BCD register and the 6-bit iteration counter, go to CONVERT.
- CONVERT: each cycle, every BCD nibble ≥ 5 gets +3, then {bcd, bin} shifts left one bit (bin MSB enters bcd bit 0). After iteration 64 (counter = 63), go to SHOW with page = 0 and page timer = 0.
- Capture events during CONVERT are ignored (`done_q` still tracks `done`).
- SHOW: page timer counts 0..PAGE_CYCLES−1; at terminal count page advances 0→1→2→0 and the timer restarts. `digits` = BCD nibbles 8·page..8·page+7; nibbles 20–23 read as 0.
- A capture event in SHOW restarts: reload and go to CONVERT (`valid` drops).
- Blanking: let m = index of the most significant nonzero BCD digit (m = 0 if value is 0). Global digit g is blanked iff g > m or g ≥ 20. Digit 0 is never blanked while valid.
- When `valid` = 0: `digits` = 0, `blank` = 8'hFF, `page` = 0.
- `digits`, `blank` are decoded from registered state only (no input-to-output combinational path).
- Reset (any state, including mid-CONVERT): state IDLE, `done_q` = 0, all registers cleared. Outputs after reset: `digits` 0, `blank` 8'hFF, `page` 0, `busy` 0, `valid` 0.
- Because `done_q` resets to 0, `done` held high through reset produces a capture at the first edge with `rst` low.

## Timing
- Capture edge E0 = first edge sampling `done`=1, `done_q`=0. `busy` high after E0.
- Iterations on edges E1..E64. After E64: `busy` = 0, `valid` = 1, page 0 shown. Total latency from `done` first high: 65 cycles.
- Each page remains stable exactly PAGE_CYCLES cycles; `digits`/`blank` change on the same edge as `page`.
- `busy` and `valid` are never simultaneously high.

## Test plan
- Reset with `done` low for 10 cycles -> `busy` 0, `valid` 0, `digits` 0, `blank` 8'hFF, `page` 0 throughout.
- `sum` = 12345678901, `done` rises, PAGE_CYCLES = 4 -> `busy` high exactly 64 cycles, `valid` at E64; page0 `digits` 32'h45678901 `blank` 8'h00; page1 32'h00000123 `blank` 8'hF8; page2 0 `blank` 8'hFF; each page 4 cycles, order 0,1,2,0.
- `sum` = 2^64−1 -> page0 32'h09551615 `blank` 8'h00; page1 32'h67440737 `blank` 8'h00; page2 32'h00001844 `blank` 8'hF0.
- `sum` = 0 -> page0 `digits` 0 `blank` 8'hFE; pages 1,2 `blank` 8'hFF.
- Second `done` rising edge at E30 of a conversion -> ignored, result matches first `sum`; `done` re-rise in SHOW with new `sum` = 92 -> `valid` drops next edge, 64 cycles later page0 32'h00000092 `blank` 8'hFC.
- `rst` pulsed at E20 with `done` held high -> outputs return to reset values; capture at first edge after `rst` low, `valid` 64 cycles later.

Source files
------------

// File: rtl/sum_bcd_pager.sv
// sum_bcd_pager
//
// Display-preparation stage for the N-Queens accelerator result. It captures
// the 64-bit solution count on a rising edge of done. An iterative
// double-dabble engine then converts the count to 20 BCD digits, one bit per
// cycle. The result is paged to an eight-digit display, eight digits per page,
// with leading zeros blanked.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   rst     in   1   synchronous active-high reset
//   sum     in   64  unsigned solution count, sampled only at capture
//   done    in   1   accelerator completion level; rising edge captures sum
//   digits  out  32  eight BCD nibbles of the current page (nibble 0 = LSD)
//   blank   out  8   per-digit blank mask (1 = show nothing)
//   page    out  2   current page index 0..2
//   busy    out  1   conversion in progress
//   valid   out  1   digits/blank reflect a completed conversion
module sum_bcd_pager #(
    parameter int PAGE_CYCLES = 268435456
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] sum,
    input  logic        done,
    output logic [31:0] digits,
    output logic [7:0]  blank,
    output logic [1:0]  page,
    output logic        busy,
    output logic        valid
);

    localparam logic [31:0] TIMER_LAST = 32'(PAGE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        SHOW
    } state_t;

    state_t      state_reg;
    logic        done_q_reg;
    logic [63:0] bin_reg;
    logic [79:0] bcd_reg;
    logic [5:0]  iter_reg;
    logic [1:0]  page_reg;
    logic [31:0] timer_reg;

    logic        capture;
    logic [79:0] bcd_adj;

    assign capture = done & ~done_q_reg;

    // Double-dabble correction: any digit of 5 or more gets +3 before the
    // shift, so that the shift carries correctly into the next decade.
    genvar gi;
    generate
        for (gi = 0; gi < 20; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_reg[4*gi +: 4] + 4'd3
                                      : bcd_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            done_q_reg <= 1'b0;
            bin_reg    <= '0;
            bcd_reg    <= '0;
            iter_reg   <= '0;
            page_reg   <= '0;
            timer_reg  <= '0;
        end else begin
            done_q_reg <= done;
            case (state_reg)
                IDLE: begin
                    if (capture) begin
                        bin_reg   <= sum;
                        bcd_reg   <= '0;
                        iter_reg  <= '0;
                        page_reg  <= '0;
                        timer_reg <= '0;
                        state_reg <= CONVERT;
                    end
                end
                CONVERT: begin
                    // The binary MSB enters BCD bit 0. The top digit cannot
                    // overflow for a 64-bit input, so the shifted-out bit is
                    // always zero.
                    bcd_reg  <= (bcd_adj << 1) | 80'(bin_reg[63]);
                    bin_reg  <= bin_reg << 1;
                    iter_reg <= iter_reg + 6'd1;
                    if (iter_reg == 6'd63) begin
                        page_reg  <= '0;
                        timer_reg <= '0;
                        state_reg <= SHOW;
                    end
                end
                SHOW: begin
                    if (capture) begin
                        bin_reg   <= sum;
                        bcd_reg   <= '0;
                        iter_reg  <= '0;
                        page_reg  <= '0;
                        timer_reg <= '0;
                        state_reg <= CONVERT;
                    end else if (timer_reg == TIMER_LAST) begin
                        timer_reg <= '0;
                        page_reg  <= (page_reg == 2'd2) ? 2'd0 : page_reg + 2'd1;
                    end else begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Find the index of the most significant nonzero digit. A value of zero
    // yields 0, which keeps digit 0 visible.
    logic [4:0] msd;
    always_comb begin
        msd = 5'd0;
        for (int k = 0; k < 20; k++) begin
            if (bcd_reg[4*k +: 4] != 4'd0) begin
                msd = 5'(k);
            end
        end
    end

    // Digits 20..23 of page 2 read as zero from the padded vector.
    logic [95:0] bcd_ext;
    logic [31:0] page_digits;
    logic [7:0]  page_blank;

    assign bcd_ext = {16'd0, bcd_reg};

    generate
        for (gi = 0; gi < 8; gi++) begin : g_out
            logic [4:0] g;
            assign g = {page_reg, 3'(gi)};
            assign page_digits[4*gi +: 4] = bcd_ext[{g, 2'b00} +: 4];
            assign page_blank[gi]         = (g > msd) || (g >= 5'd20);
        end
    endgenerate

    assign busy   = (state_reg == CONVERT);
    assign valid  = (state_reg == SHOW);
    assign digits = valid ? page_digits : 32'd0;
    assign blank  = valid ? page_blank : 8'hFF;
    assign page   = valid ? page_reg : 2'd0;

endmodule

// File: tb/tb_sum_bcd_pager.sv
module tb_sum_bcd_pager;

    localparam int PC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] sum = '0;
    logic        done = 1'b0;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic [1:0]  page;
    logic        busy;
    logic        valid;

    int checks = 0;
    int failures = 0;

    sum_bcd_pager #(.PAGE_CYCLES(PC)) dut (
        .clk    (clk),
        .rst    (rst),
        .sum    (sum),
        .done   (done),
        .digits (digits),
        .blank  (blank),
        .page   (page),
        .busy   (busy),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy got=%b want=0", tag, busy); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL %s valid got=%b want=0", tag, valid); end
        checks++; if (digits !== 32'd0) begin failures++; $display("FAIL %s digits got=%h want=0", tag, digits); end
        checks++; if (blank !== 8'hFF) begin failures++; $display("FAIL %s blank got=%h want=ff", tag, blank); end
        checks++; if (page !== 2'd0) begin failures++; $display("FAIL %s page got=%0d want=0", tag, page); end
    endtask

    // Produce a rising edge on done; returns just after the capture edge E0.
    task automatic start_capture(input logic [63:0] v);
        done = 1'b0;
        step();
        sum  = v;
        done = 1'b1;
        step();
        $display("capture sum=%0d busy=%b", v, busy);
    endtask

    // Count cycles with busy high (already = busy samples seen so far),
    // bounded, then require exactly 64 and valid high.
    task automatic wait_done(input int already, input string tag);
        int n;
        n = already;
        while (busy === 1'b1 && n < 200) begin
            checks++;
            if (valid === 1'b1) begin
                failures++;
                $display("FAIL %s busy_valid_overlap at busy cycle %0d", tag, n);
            end
            n++;
            step();
        end
        checks++;
        if (n != 64) begin failures++; $display("FAIL %s busy_cycles got=%0d want=64", tag, n); end
        checks++;
        if (valid !== 1'b1) begin failures++; $display("FAIL %s valid_after_convert got=%b want=1", tag, valid); end
        $display("%s conversion busy_cycles=%0d valid=%b", tag, n, valid);
    endtask

    // Starting right after E64, check pages 0,1,2,0 for PC cycles each.
    task automatic show_check(input string tag,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [31:0] de [3];
        logic [7:0]  be [3];
        de[0] = d0; de[1] = d1; de[2] = d2;
        be[0] = b0; be[1] = b1; be[2] = b2;
        for (int p = 0; p < 4; p++) begin
            int pe;
            pe = (p == 3) ? 0 : p;
            for (int c = 0; c < PC; c++) begin
                checks++;
                if (page !== 2'(pe)) begin failures++; $display("FAIL %s page got=%0d want=%0d (slot %0d cyc %0d)", tag, page, pe, p, c); end
                checks++;
                if (digits !== de[pe]) begin failures++; $display("FAIL %s digits got=%h want=%h (page %0d cyc %0d)", tag, digits, de[pe], pe, c); end
                checks++;
                if (blank !== be[pe]) begin failures++; $display("FAIL %s blank got=%h want=%h (page %0d cyc %0d)", tag, blank, be[pe], pe, c); end
                step();
            end
            $display("%s page=%0d digits=%h blank=%h", tag, pe, de[pe], be[pe]);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_idle_outputs("reset");
        end
        rst = 1'b0;
        step();
        check_idle_outputs("post_reset");
        $display("reset: outputs idle for 10 cycles");
    endtask

    task automatic test_basic();
        start_capture(64'd12345678901);
        wait_done(0, "basic");
        show_check("basic", 32'h45678901, 32'h00000123, 32'h00000000, 8'h00, 8'hF8, 8'hFF);
    endtask

    task automatic test_max();
        start_capture(64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(0, "max");
        show_check("max", 32'h09551615, 32'h67440737, 32'h00001844, 8'h00, 8'h00, 8'hF0);
    endtask

    task automatic test_zero();
        start_capture(64'd0);
        wait_done(0, "zero");
        show_check("zero", 32'h0, 32'h0, 32'h0, 8'hFE, 8'hFF, 8'hFF);
    endtask

    task automatic test_back_to_back();
        start_capture(64'd12345678901);
        repeat (28) step();
        done = 1'b0;
        step();
        sum  = 64'd777;
        done = 1'b1;
        step();
        wait_done(30, "ignore");
        show_check("ignore", 32'h45678901, 32'h00000123, 32'h00000000, 8'h00, 8'hF8, 8'hFF);
        done = 1'b0;
        step();
        sum  = 64'd92;
        done = 1'b1;
        step();
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL recapture valid got=%b want=0", valid); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL recapture busy got=%b want=1", busy); end
        $display("recapture in SHOW sum=92 valid=%b busy=%b", valid, busy);
        wait_done(0, "recap");
        show_check("recap", 32'h00000092, 32'h0, 32'h0, 8'hFC, 8'hFF, 8'hFF);
    endtask

    task automatic test_reset_mid();
        start_capture(64'd12345678901);
        repeat (20) step();
        rst = 1'b1;
        step();
        check_idle_outputs("midreset0");
        step();
        check_idle_outputs("midreset1");
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL midreset_recapture busy got=%b want=1", busy); end
        $display("reset mid-convert, capture after release busy=%b", busy);
        wait_done(0, "midreset");
        show_check("midreset", 32'h45678901, 32'h00000123, 32'h00000000, 8'h00, 8'hF8, 8'hFF);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
